// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Branch resolution and direction prediction for the 5-stage
//               pipeline. The IF side predicts jal/B-type direction using a
//               static or dynamic (saturating counter table) scheme and
//               supplies the PC-relative target. The EX side resolves
//               B-type/jal/jalr from comparator flags, flags a mispredict
//               flush with the redirect PC, trains the table and keeps
//               wrapping performance counters.
// Ports       : clk, rst_n            clock, async active-low reset
//               if_*_i / pred_*_o     fetch-side lookup and prediction
//               ex_*_i                execute-side resolve inputs
//               pc_sel_o, flush_o,    actual direction, mispredict kill,
//               redirect_pc_o         corrected fetch PC
//               perf_*_o              branch / mispredict event counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int IDX_W     = 6,
    parameter int CTR_W     = 2,
    parameter int PRED_MODE = 2,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    input  logic [XLEN-1:0]   if_pc_i,
    input  logic [6:0]        if_opcode_i,
    input  logic [XLEN-1:0]   if_imm_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    input  logic              ex_valid_i,
    input  logic [6:0]        ex_opcode_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [1:0]        ex_comp_out_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [XLEN-1:0]   ex_target_i,
    input  logic              ex_pred_taken_i,
    output logic              pc_sel_o,
    output logic              flush_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [PERF_W-1:0] perf_branches_o,
    output logic [PERF_W-1:0] perf_mispred_o
);

    localparam logic [6:0]        OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]        OPC_JAL    = 7'b1101111;
    localparam logic [6:0]        OPC_JALR   = 7'b1100111;
    localparam logic [1:0]        CMP_EQ     = 2'b01;
    localparam logic [1:0]        CMP_LT     = 2'b10;
    localparam logic [1:0]        CMP_GT     = 2'b11;
    localparam logic [XLEN-1:0]   PC_STEP    = XLEN'(4);
    localparam logic [PERF_W-1:0] PERF_ONE   = PERF_W'(1);

    // ------------------------------------------------------------------
    // EX-side decode and actual direction
    // ------------------------------------------------------------------
    logic ex_is_b, ex_is_jal, ex_is_jalr;
    logic b_cond;

    assign ex_is_b    = (ex_opcode_i == OPC_BRANCH);
    assign ex_is_jal  = (ex_opcode_i == OPC_JAL);
    assign ex_is_jalr = (ex_opcode_i == OPC_JALR);

    // Signed/unsigned variants share a decode: the comparator already
    // produced flags in the right signedness.
    always_comb begin
        b_cond = 1'b0;
        casez (ex_funct3_i)
            3'b000:  b_cond = (ex_comp_out_i == CMP_EQ);
            3'b001:  b_cond = (ex_comp_out_i != CMP_EQ);
            3'b1?0:  b_cond = (ex_comp_out_i == CMP_LT);
            3'b1?1:  b_cond = (ex_comp_out_i == CMP_EQ) || (ex_comp_out_i == CMP_GT);
            default: b_cond = 1'b0;
        endcase
    end

    logic ex_act;
    assign ex_act = rst_n & ex_valid_i;

    assign pc_sel_o = ex_act & (ex_is_jal | ex_is_jalr | (ex_is_b & b_cond));

    // jalr is never predicted, so it always redirects once it reaches EX.
    assign flush_o = ex_act & (ex_is_jalr |
                               ((ex_is_b | ex_is_jal) & (pc_sel_o != ex_pred_taken_i)));

    assign redirect_pc_o = !rst_n   ? '0 :
                           pc_sel_o ? ex_target_i : (ex_pc_i + PC_STEP);

    // ------------------------------------------------------------------
    // IF-side prediction
    // ------------------------------------------------------------------
    logic if_is_b, if_is_jal;
    logic dyn_pred;
    logic b_pred;

    assign if_is_b   = (if_opcode_i == OPC_BRANCH);
    assign if_is_jal = (if_opcode_i == OPC_JAL);

    generate
        if (PRED_MODE == 2) begin : g_dyn_table
            localparam int              DEPTH    = 1 << IDX_W;
            localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
            localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
            localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

            logic [CTR_W-1:0] table_q [DEPTH];
            logic [CTR_W-1:0] ctr_d;
            logic [IDX_W-1:0] if_idx;
            logic [IDX_W-1:0] ex_idx;
            logic             upd_en;

            // Tag-less: PCs that differ only above bit IDX_W+1 alias.
            assign if_idx = if_pc_i[IDX_W+1:2];
            assign ex_idx = ex_pc_i[IDX_W+1:2];
            assign upd_en = ex_valid_i & ex_is_b;

            always_comb begin
                ctr_d = table_q[ex_idx];
                if (b_cond) begin
                    if (ctr_d != CTR_MAX) ctr_d = ctr_d + CTR_ONE;
                end else begin
                    if (ctr_d != '0) ctr_d = ctr_d - CTR_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
                end else if (upd_en) begin
                    table_q[ex_idx] <= ctr_d;
                end
            end

            // Reads the registered table, so a same-cycle update to the
            // same entry is not visible until the next cycle.
            assign dyn_pred = table_q[if_idx][CTR_W-1];
        end else begin : g_static
            assign dyn_pred = 1'b0;
        end
    endgenerate

    always_comb begin
        b_pred = 1'b0;
        case (PRED_MODE)
            1:       b_pred = if_imm_i[XLEN-1];   // backward taken
            2:       b_pred = dyn_pred;
            default: b_pred = 1'b0;
        endcase
    end

    assign pred_taken_o  = rst_n & if_valid_i & (if_is_jal | (if_is_b & b_pred));
    assign pred_target_o = rst_n ? (if_pc_i + if_imm_i) : '0;

    // ------------------------------------------------------------------
    // Performance counters (wrap naturally)
    // ------------------------------------------------------------------
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    always_comb begin
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (ex_valid_i && ex_is_b) perf_br_d  = perf_br_q + PERF_ONE;
        if (flush_o)               perf_mis_d = perf_mis_q + PERF_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_branches_o = perf_br_q;
    assign perf_mispred_o  = perf_mis_q;

endmodule
`default_nettype wire
